pad_cfg_seq: RTL and testbench



---
 rtl/pad_cfg_seq_if.sv | 24 ++
 rtl/pad_cfg_seq.sv | 211 +++++++++++++++++++++
 tb/tb_pad_cfg_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pad_cfg_seq_if.sv
// Configuration request/response port of the pad configuration controller.
// One request per valid&ready cycle, one rvalid pulse per request one cycle later.
interface pad_cfg_seq_if #(
    parameter int AW = 6
) ();
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_write;
    logic [AW-1:0] cfg_addr;
    logic [5:0]    cfg_wdata;
    logic          cfg_rvalid;
    logic [5:0]    cfg_rdata;
    logic          cfg_err;

    modport master (
        output cfg_valid, cfg_write, cfg_addr, cfg_wdata,
        input  cfg_ready, cfg_rvalid, cfg_rdata, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_write, cfg_addr, cfg_wdata,
        output cfg_ready, cfg_rvalid, cfg_rdata, cfg_err
    );
endinterface

// File: rtl/pad_cfg_seq.sv
// Per-pad OE/PU/PD/CS/SL/IE storage with staged group release of drivers and pulls
// after reset or freeze, so the whole pad ring never starts switching on one cycle.
module pad_cfg_seq #(
    parameter int NUM_BIDIR_PADS = 40,
    parameter int GROUP_SIZE     = 8,
    parameter int STAGE_CYCLES   = 16,
    parameter int AW             = $clog2(NUM_BIDIR_PADS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    pad_cfg_seq_if.slave              cfg,
    output logic                      seq_done,
    output logic [NUM_BIDIR_PADS-1:0] pad_oe,
    output logic [NUM_BIDIR_PADS-1:0] pad_pu,
    output logic [NUM_BIDIR_PADS-1:0] pad_pd,
    output logic [NUM_BIDIR_PADS-1:0] pad_cs,
    output logic [NUM_BIDIR_PADS-1:0] pad_sl,
    output logic [NUM_BIDIR_PADS-1:0] pad_ie
);
    localparam int N          = NUM_BIDIR_PADS;
    localparam int NUM_GROUPS = (N + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int CW         = $clog2(STAGE_CYCLES + 1);
    localparam int GW         = $clog2(NUM_GROUPS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STAGE_CYCLES - 1);
    localparam logic [GW-1:0] GRP_LAST = GW'(NUM_GROUPS - 1);
    localparam logic [AW:0]   ADDR_LIM = (AW + 1)'(N);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Pull-up wins when both pulls are requested.
    function automatic logic [5:0] norm_cfg(input logic [5:0] w);
        return {w[5:3], w[2] & ~w[1], w[1:0]};
    endfunction

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [GW-1:0] grp_r, grp_s;
    logic [N-1:0]  rel_r, rel_s, grp_mask_s;
    logic [N-1:0]  oe_r, pu_r, pd_r, cs_r, sl_r, ie_r;
    logic [N-1:0]  oe_s, pu_s, pd_s, cs_s, sl_s, ie_s;
    logic          ready_r;
    logic          accept_s, in_range_s;
    logic [5:0]    wnorm_s, rdata_s;
    logic          err_s;

    assign accept_s   = cfg.cfg_valid & ready_r;
    assign in_range_s = ({1'b0, cfg.cfg_addr} < ADDR_LIM);
    assign wnorm_s    = norm_cfg(cfg.cfg_wdata);

    // Pads belonging to the group currently being staged.
    always_comb begin
        grp_mask_s = '0;
        for (int i = 0; i < N; i++) begin
            grp_mask_s[i] = ((i / GROUP_SIZE) == int'(grp_r));
        end
    end

    // Sequencer next state: freeze overrides everything and clears the release mask.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        grp_s   = grp_r;
        rel_s   = rel_r;
        if (freeze) begin
            state_s = ST_HOLD;
            cnt_s   = '0;
            grp_s   = '0;
            rel_s   = '0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    state_s = ST_STAGE;
                    cnt_s   = '0;
                    grp_s   = '0;
                end
                ST_STAGE: begin
                    if (cnt_r == CNT_LAST) begin
                        rel_s = rel_r | grp_mask_s;
                        cnt_s = '0;
                        grp_s = grp_r + GW'(1);
                        if (grp_r == GRP_LAST) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_STAGE;
                        end
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s = ST_HOLD;
                    cnt_s   = '0;
                    grp_s   = '0;
                    rel_s   = '0;
                end
            endcase
        end
    end

    // Storage update and response data for the accepted request.
    always_comb begin
        oe_s    = oe_r;
        pu_s    = pu_r;
        pd_s    = pd_r;
        cs_s    = cs_r;
        sl_s    = sl_r;
        ie_s    = ie_r;
        rdata_s = 6'd0;
        err_s   = 1'b0;
        if (accept_s) begin
            if (in_range_s) begin
                if (cfg.cfg_write) begin
                    oe_s[cfg.cfg_addr] = wnorm_s[0];
                    pu_s[cfg.cfg_addr] = wnorm_s[1];
                    pd_s[cfg.cfg_addr] = wnorm_s[2];
                    cs_s[cfg.cfg_addr] = wnorm_s[3];
                    sl_s[cfg.cfg_addr] = wnorm_s[4];
                    ie_s[cfg.cfg_addr] = wnorm_s[5];
                    rdata_s            = wnorm_s;
                end else begin
                    rdata_s = {ie_r[cfg.cfg_addr], sl_r[cfg.cfg_addr], cs_r[cfg.cfg_addr],
                               pd_r[cfg.cfg_addr], pu_r[cfg.cfg_addr], oe_r[cfg.cfg_addr]};
                end
            end else begin
                err_s = 1'b1;
            end
        end else begin
            err_s = 1'b0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_HOLD;
            cnt_r    <= '0;
            grp_r    <= '0;
            rel_r    <= '0;
            seq_done <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            grp_r    <= grp_s;
            rel_r    <= rel_s;
            seq_done <= (state_s == ST_DONE);
        end
    end

    // Configuration storage; input enable defaults on so pads can be observed after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oe_r <= '0;
            pu_r <= '0;
            pd_r <= '0;
            cs_r <= '0;
            sl_r <= '0;
            ie_r <= '1;
        end else begin
            oe_r <= oe_s;
            pu_r <= pu_s;
            pd_r <= pd_s;
            cs_r <= cs_s;
            sl_r <= sl_s;
            ie_r <= ie_s;
        end
    end

    // Request port: always ready out of reset, one response per accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r        <= 1'b0;
            cfg.cfg_ready  <= 1'b0;
            cfg.cfg_rvalid <= 1'b0;
            cfg.cfg_rdata  <= 6'd0;
            cfg.cfg_err    <= 1'b0;
        end else begin
            ready_r        <= 1'b1;
            cfg.cfg_ready  <= 1'b1;
            cfg.cfg_rvalid <= accept_s;
            cfg.cfg_rdata  <= rdata_s;
            cfg.cfg_err    <= err_s;
        end
    end

    // Pad-side controls built from next-state values so a write lands on its accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_oe <= '0;
            pad_pu <= '0;
            pad_pd <= '0;
            pad_cs <= '0;
            pad_sl <= '0;
            pad_ie <= '1;
        end else begin
            pad_oe <= oe_s & rel_s;
            pad_pu <= pu_s & rel_s;
            pad_pd <= pd_s & rel_s;
            pad_cs <= cs_s;
            pad_sl <= sl_s;
            pad_ie <= ie_s;
        end
    end
endmodule

// File: tb/tb_pad_cfg_seq.sv
// Self-checking bench for pad_cfg_seq: response scoreboard plus per-scenario pad checks.
module tb_pad_cfg_seq;
    localparam int N  = 40;
    localparam int AW = 6;

    logic         clk;
    logic         rst;
    logic         freeze;
    logic         seq_done;
    logic [N-1:0] pad_oe, pad_pu, pad_pd, pad_cs, pad_sl, pad_ie;

    pad_cfg_seq_if #(.AW(AW)) bus ();

    pad_cfg_seq #(
        .NUM_BIDIR_PADS(N), .GROUP_SIZE(8), .STAGE_CYCLES(16), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .cfg(bus), .seq_done(seq_done),
        .pad_oe(pad_oe), .pad_pu(pad_pu), .pad_pd(pad_pd),
        .pad_cs(pad_cs), .pad_sl(pad_sl), .pad_ie(pad_ie)
    );

    typedef struct {
        int         due;
        logic [5:0] rdata;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       exp_e;
    logic [5:0] model[N];
    int         edges;
    int         n_vec;
    int         n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge numbering: edge 1 is the first rising edge after rst deasserts.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) model[i] = 6'h20;
    endtask

    // Advance to the next falling edge and retire any response due there.
    task automatic tick();
        @(negedge clk);
        if (sb_q.size() > 0 && sb_q[0].due == edges) begin
            exp_e = sb_q.pop_front();
            n_vec++;
            if (bus.cfg_rvalid !== 1'b1 || bus.cfg_rdata !== exp_e.rdata || bus.cfg_err !== exp_e.err) begin
                n_err++;
                $display("FAIL rsp@%0d: got rvalid=%b rdata=%h err=%b, want rvalid=1 rdata=%h err=%b",
                         edges, bus.cfg_rvalid, bus.cfg_rdata, bus.cfg_err, exp_e.rdata, exp_e.err);
            end
        end else if (!rst && bus.cfg_rvalid !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_rvalid@%0d: got rvalid=%b, want 0", edges, bus.cfg_rvalid);
        end
    endtask

    task automatic req(input logic w, input logic [5:0] a, input logic [5:0] d);
        logic [5:0] nd;
        tick();
        bus.cfg_valid = 1'b1;
        bus.cfg_write = w;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        if (int'(a) < N) begin
            if (w) begin
                nd = d;
                if (d[1] && d[2]) nd[2] = 1'b0;
                model[a] = nd;
            end
            sb_q.push_back('{due: edges + 1, rdata: model[a], err: 1'b0});
        end else begin
            sb_q.push_back('{due: edges + 1, rdata: 6'h00, err: 1'b1});
        end
    endtask

    task automatic idle();
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_edge(input int k);
        int guard;
        guard = 0;
        while (edges < k && guard < 300) begin
            tick();
            guard++;
        end
        n_vec++;
        if (edges != k) begin
            n_err++;
            $display("FAIL wait_edge: reached edge %0d, want %0d", edges, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_write = 1'b0; bus.cfg_addr = 6'd0; bus.cfg_wdata = 6'd0;
        model_reset();
        repeat (3) tick();
        n_vec++;
        if (bus.cfg_ready !== 1'b0 || bus.cfg_rvalid !== 1'b0 || bus.cfg_rdata !== 6'd0 || bus.cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_port: got ready=%b rvalid=%b rdata=%h err=%b, want 0 0 00 0",
                     bus.cfg_ready, bus.cfg_rvalid, bus.cfg_rdata, bus.cfg_err);
        end
        n_vec++;
        if (seq_done !== 1'b0 || pad_oe !== '0 || pad_pu !== '0 || pad_pd !== '0 || pad_cs !== '0
            || pad_sl !== '0 || pad_ie !== {N{1'b1}}) begin
            n_err++;
            $display("FAIL reset_pads: got done=%b oe=%h ie=%h, want done=0 oe=0 ie=all ones", seq_done, pad_oe, pad_ie);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (bus.cfg_ready !== 1'b1 || seq_done !== 1'b0) begin
            n_err++;
            $display("FAIL ready_rise: got ready=%b done=%b, want 1 0", bus.cfg_ready, seq_done);
        end
    endtask

    task automatic test_staging();
        req(1'b1, 6'd3, 6'h01);
        req(1'b1, 6'd39, 6'h01);
        idle();
        wait_edge(16);
        n_vec++;
        if (pad_oe[3] !== 1'b0) begin
            n_err++; $display("FAIL grp0_early: got pad_oe[3]=%b, want 0", pad_oe[3]);
        end
        wait_edge(17);
        n_vec++;
        if (pad_oe[3] !== 1'b1 || pad_oe[39] !== 1'b0 || pad_ie[3] !== 1'b0) begin
            n_err++;
            $display("FAIL grp0_release: got oe3=%b oe39=%b ie3=%b, want 1 0 0", pad_oe[3], pad_oe[39], pad_ie[3]);
        end
        // Write to a group-1 pad lands on the same edge as group 1 release (edge 33).
        wait_edge(31);
        req(1'b1, 6'd10, 6'h01);
        idle();
        n_vec++;
        if (pad_oe[10] !== 1'b1 || edges != 33) begin
            n_err++; $display("FAIL write_at_release: got oe10=%b at edge %0d, want 1 at 33", pad_oe[10], edges);
        end
        wait_edge(80);
        n_vec++;
        if (pad_oe[39] !== 1'b0 || seq_done !== 1'b0) begin
            n_err++; $display("FAIL last_early: got oe39=%b done=%b, want 0 0", pad_oe[39], seq_done);
        end
        wait_edge(81);
        n_vec++;
        if (pad_oe[39] !== 1'b1 || seq_done !== 1'b1) begin
            n_err++; $display("FAIL last_release: got oe39=%b done=%b, want 1 1", pad_oe[39], seq_done);
        end
    endtask

    task automatic test_normalise();
        req(1'b1, 6'd5, 6'h06);
        req(1'b0, 6'd5, 6'h00);
        idle();
        n_vec++;
        if (pad_pu[5] !== 1'b1 || pad_pd[5] !== 1'b0 || model[5] !== 6'h02) begin
            n_err++; $display("FAIL normalise: got pu5=%b pd5=%b, want 1 0", pad_pu[5], pad_pd[5]);
        end
    endtask

    task automatic test_bad_addr();
        logic [6*N-1:0] snap;
        snap = {pad_oe, pad_pu, pad_pd, pad_cs, pad_sl, pad_ie};
        req(1'b0, 6'd45, 6'h00);
        req(1'b1, 6'd40, 6'h3F);
        idle();
        n_vec++;
        if ({pad_oe, pad_pu, pad_pd, pad_cs, pad_sl, pad_ie} !== snap) begin
            n_err++; $display("FAIL bad_addr_pads: got oe=%h pu=%h, want oe=%h unchanged", pad_oe, pad_pu, snap[6*N-1 -: N]);
        end
    endtask

    task automatic test_freeze();
        req(1'b1, 6'd6, 6'h03);
        freeze = 1'b1;
        idle();
        n_vec++;
        if (pad_oe !== '0 || pad_pu !== '0 || pad_pd !== '0 || seq_done !== 1'b0 || pad_ie[6] !== 1'b0) begin
            n_err++;
            $display("FAIL freeze_safe: got oe=%h pu=%h pd=%h done=%b ie6=%b, want 0 0 0 0 0",
                     pad_oe, pad_pu, pad_pd, seq_done, pad_ie[6]);
        end
        tick();
        tick();
        freeze = 1'b0;
        repeat (16) tick();
        n_vec++;
        if (pad_oe[3] !== 1'b0 || pad_oe[6] !== 1'b0 || seq_done !== 1'b0) begin
            n_err++; $display("FAIL restart_early: got oe3=%b oe6=%b done=%b, want 0 0 0", pad_oe[3], pad_oe[6], seq_done);
        end
        tick();
        n_vec++;
        if (pad_oe[3] !== 1'b1 || pad_oe[6] !== 1'b1 || pad_pu[6] !== 1'b1) begin
            n_err++; $display("FAIL restart_release: got oe3=%b oe6=%b pu6=%b, want 1 1 1", pad_oe[3], pad_oe[6], pad_pu[6]);
        end
    endtask

    task automatic test_back_to_back();
        req(1'b1, 6'd0, 6'h21);
        req(1'b0, 6'd0, 6'h00);
        idle();
        n_vec++;
        if (model[0] !== 6'h21 || sb_q.size() != 0) begin
            n_err++; $display("FAIL back_to_back: got %0d responses pending, want 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        req(1'b1, 6'd1, 6'h01);
        req(1'b1, 6'd9, 6'h01);
        idle();
        wait_edge(40);
        n_vec++;
        if (pad_oe[1] !== 1'b1 || pad_oe[9] !== 1'b1) begin
            n_err++; $display("FAIL pre_reset: got oe1=%b oe9=%b, want 1 1", pad_oe[1], pad_oe[9]);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (pad_oe !== '0 || pad_ie !== {N{1'b1}} || bus.cfg_ready !== 1'b0 || seq_done !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got oe=%h ie=%h ready=%b done=%b, want 0 all-ones 0 0", pad_oe, pad_ie, bus.cfg_ready, seq_done);
        end
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        req(1'b0, 6'd1, 6'h00);
        req(1'b0, 6'd9, 6'h00);
        idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_staging();
        test_normalise();
        test_bad_addr();
        test_freeze();
        test_back_to_back();
        test_reset_mid();
        tick();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL drain: got %0d responses outstanding, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
